// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the lcd_cmd_seq sequencer: FSM state encoding,
// HD44780 command codes, the fixed 4-bit initialisation list and the
// helpers that choose the post-issue wait for each byte.
// ---------------------------------------------------------------------------
package lcd_pkg;

   typedef enum logic [2:0] {
      PWRUP      = 3'd0,
      INIT_ISSUE = 3'd1,
      INIT_WAIT  = 3'd2,
      IDLE       = 3'd3,
      USR_ISSUE  = 3'd4,
      USR_WAIT   = 3'd5
   } state_t;

   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_HOME      = 8'h02;
   localparam logic [7:0] CMD_FUNC_4BIT = 8'h28;
   localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
   localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
   localparam logic [7:0] WAKE_33       = 8'h33;
   localparam logic [7:0] WAKE_32       = 8'h32;

   localparam int INIT_LEN = 6;

   // Initialisation list, sent in order with rs=0.
   function automatic logic [7:0] init_rom(input logic [2:0] idx);
      logic [7:0] val;
      case (idx)
         3'd0:    val = WAKE_33;
         3'd1:    val = WAKE_32;
         3'd2:    val = CMD_FUNC_4BIT;
         3'd3:    val = CMD_DISP_ON;
         3'd4:    val = CMD_CLEAR;
         3'd5:    val = CMD_ENTRY_INC;
         default: val = CMD_ENTRY_INC;
      endcase
      return val;
   endfunction

   // Clear and home are the only commands needing the long execution wait;
   // a data byte with the same value is just a character.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return (rs == 1'b0) && ((data == CMD_CLEAR) || (data == CMD_HOME));
   endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// ---------------------------------------------------------------------------
// lcd_wait_timer
// Loadable down-counter that stops at zero.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (count <- RST_VAL)
//   load       load load_val this cycle (takes priority over counting)
//   load_val   value to load (N-1 for an N-cycle wait)
//   zero       count currently reads zero
// ---------------------------------------------------------------------------
module lcd_wait_timer #(
   parameter int                CNT_W   = 18,
   parameter logic [CNT_W-1:0]  RST_VAL = {CNT_W{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: load, else decrement, holding at zero so it never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != {CNT_W{1'b0}}) begin
         cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= RST_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/lcd_cmd_seq.sv
// ---------------------------------------------------------------------------
// lcd_cmd_seq
// Command sequencer in front of lcd_ctrl. After reset it waits the LCD
// power-up time, sends the fixed 4-bit init list, then accepts user
// command/data bytes on a valid/ready handshake. lcd_ctrl has no busy flag,
// so every byte is followed by a fixed cycle wait chosen by its type.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   char_valid   user byte available (held until accepted)
//   char_rs      user byte type: 1=data, 0=command
//   char_data    user byte
//   char_ready   sequencer accepts a user byte this cycle
//   init_done    init list complete, stays high until reset
//   rs, rw       to lcd_ctrl; rw is always 0 (write only)
//   datain       to lcd_ctrl, stable from one issue to the next
//   start        to lcd_ctrl, one-cycle pulse per byte
// ---------------------------------------------------------------------------
module lcd_cmd_seq
   import lcd_pkg::*;
#(
   parameter int POWERUP_CYCLES = 150000,
   parameter int CMD_CYCLES     = 500,
   parameter int CLEAR_CYCLES   = 16000,
   parameter int CNT_W          = 18
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       char_valid,
   input  logic       char_rs,
   input  logic [7:0] char_data,
   output logic       char_ready,
   output logic       init_done,
   output logic       rs,
   output logic       rw,
   output logic [7:0] datain,
   output logic       start
);

   localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(POWERUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
   localparam logic [2:0]       LAST_IDX   = 3'(INIT_LEN - 1);

   state_t           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic             rs_q, rs_d;
   logic [7:0]       datain_q, datain_d;
   logic             start_q, start_d;
   logic             char_ready_q, char_ready_d;
   logic             init_done_q, init_done_d;

   logic             timer_load;
   logic [CNT_W-1:0] timer_val;
   logic             timer_zero;

   // Reset value covers the power-up wait, so PWRUP needs no explicit load.
   lcd_wait_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (PWRUP_LOAD)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (timer_val),
      .zero     (timer_zero)
   );

   // Next-state and next-output logic. Outputs are computed one cycle ahead
   // so start/rs/datain/char_ready come straight from flops. The timer is
   // loaded on the ISSUE cycle, so the wait state then lasts exactly N cycles.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      rs_d         = rs_q;
      datain_d     = datain_q;
      start_d      = 1'b0;
      char_ready_d = char_ready_q;
      init_done_d  = init_done_q;
      timer_load   = 1'b0;
      timer_val    = CMD_LOAD;

      case (state_q)
         PWRUP: begin
            if (timer_zero) begin
               state_d  = INIT_ISSUE;
               rs_d     = 1'b0;
               datain_d = init_rom(idx_q);
               start_d  = 1'b1;
            end else begin
               state_d  = PWRUP;
            end
         end

         INIT_ISSUE: begin
            state_d    = INIT_WAIT;
            timer_load = 1'b1;
            timer_val  = is_long_cmd(rs_q, datain_q) ? CLEAR_LOAD : CMD_LOAD;
         end

         INIT_WAIT: begin
            if (timer_zero) begin
               if (idx_q == LAST_IDX) begin
                  state_d      = IDLE;
                  init_done_d  = 1'b1;
                  char_ready_d = 1'b1;
               end else begin
                  idx_d    = idx_q + 3'd1;
                  state_d  = INIT_ISSUE;
                  datain_d = init_rom(idx_q + 3'd1);
                  start_d  = 1'b1;
               end
            end else begin
               state_d = INIT_WAIT;
            end
         end

         IDLE: begin
            if (char_valid && char_ready_q) begin
               state_d      = USR_ISSUE;
               rs_d         = char_rs;
               datain_d     = char_data;
               start_d      = 1'b1;
               char_ready_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end

         USR_ISSUE: begin
            state_d    = USR_WAIT;
            timer_load = 1'b1;
            timer_val  = is_long_cmd(rs_q, datain_q) ? CLEAR_LOAD : CMD_LOAD;
         end

         USR_WAIT: begin
            if (timer_zero) begin
               state_d      = IDLE;
               char_ready_d = 1'b1;
            end else begin
               state_d = USR_WAIT;
            end
         end

         default: begin
            // Illegal encoding: restart the whole power-up sequence.
            state_d      = PWRUP;
            idx_d        = 3'd0;
            rs_d         = 1'b0;
            datain_d     = 8'h00;
            char_ready_d = 1'b0;
            init_done_d  = 1'b0;
            timer_load   = 1'b1;
            timer_val    = PWRUP_LOAD;
         end
      endcase
   end

   // State and output registers; reset cuts a start pulse short immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= PWRUP;
         idx_q        <= 3'd0;
         rs_q         <= 1'b0;
         datain_q     <= 8'h00;
         start_q      <= 1'b0;
         char_ready_q <= 1'b0;
         init_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         rs_q         <= rs_d;
         datain_q     <= datain_d;
         start_q      <= start_d;
         char_ready_q <= char_ready_d;
         init_done_q  <= init_done_d;
      end
   end

   assign rs         = rs_q;
   assign rw         = 1'b0;
   assign datain     = datain_q;
   assign start      = start_q;
   assign char_ready = char_ready_q;
   assign init_done  = init_done_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_lcd_cmd_seq
// Self-checking bench for lcd_cmd_seq with short timing parameters.
// The reference model predicts, per cycle after reset release, whether a
// start pulse is due and which rs/byte is being driven, from the issue
// times derived arithmetically from the wait rules, plus a "free at" cycle
// for the user handshake.
// ---------------------------------------------------------------------------
module tb_lcd_cmd_seq;

   localparam int P_PWR   = 10;
   localparam int P_CMD   = 4;
   localparam int P_CLEAR = 8;

   logic       clk;
   logic       rst;
   logic       char_valid;
   logic       char_rs;
   logic [7:0] char_data;
   logic       char_ready;
   logic       init_done;
   logic       rs;
   logic       rw;
   logic [7:0] datain;
   logic       start;

   lcd_cmd_seq #(
      .POWERUP_CYCLES (P_PWR),
      .CMD_CYCLES     (P_CMD),
      .CLEAR_CYCLES   (P_CLEAR),
      .CNT_W          (18)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .char_valid (char_valid),
      .char_rs    (char_rs),
      .char_data  (char_data),
      .char_ready (char_ready),
      .init_done  (init_done),
      .rs         (rs),
      .rw         (rw),
      .datain     (datain),
      .start      (start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [7:0] rom [6];
   int         init_t [6];
   int         init_end;
   int         cyc;
   int         free_at;
   int         usr_at;
   logic       usr_rs;
   logic [7:0] usr_data;
   logic       exp_rs;
   logic [7:0] exp_data;
   logic       acc_pending;
   bit         hold_mode;
   logic [8:0] tx_q [$];
   int         obs_starts = 0;
   int         exp_starts = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int wlen(input logic r, input logic [7:0] d);
      if (!r && (d == 8'h01 || d == 8'h02)) return P_CLEAR;
      return P_CMD;
   endfunction

   task automatic model_reset();
      cyc         = 0;
      free_at     = init_end;
      usr_at      = -1;
      exp_rs      = 1'b0;
      exp_data    = 8'h00;
      acc_pending = 1'b0;
   endtask

   // Advance n cycles; each iteration samples at the falling edge.
   task automatic run_cycles(input int n);
      logic exp_start;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         exp_start = 1'b0;
         for (int k = 0; k < 6; k++) begin
            if (cyc == init_t[k]) begin
               exp_start = 1'b1;
               exp_rs    = 1'b0;
               exp_data  = rom[k];
            end
         end
         if (cyc == usr_at) begin
            exp_start = 1'b1;
            exp_rs    = usr_rs;
            exp_data  = usr_data;
         end
         if (start)     obs_starts++;
         if (exp_start) exp_starts++;
         chk("start",      32'(start),      32'(exp_start));
         chk("rs",         32'(rs),         32'(exp_rs));
         chk("datain",     32'(datain),     32'(exp_data));
         chk("rw",         32'(rw),         32'(1'b0));
         chk("char_ready", 32'(char_ready), 32'(cyc >= free_at));
         chk("init_done",  32'(init_done),  32'(cyc >= init_end));

         // User side: drop valid after acceptance, present queued bytes.
         if (acc_pending) begin
            char_valid  = 1'b0;
            acc_pending = 1'b0;
         end
         if (!char_valid && tx_q.size() > 0 && (hold_mode || $urandom_range(0, 2) == 0)) begin
            {char_rs, char_data} = tx_q.pop_front();
            char_valid = 1'b1;
         end else if (!char_valid) begin
            char_rs   = 1'($urandom_range(0, 1));
            char_data = 8'($urandom_range(0, 255));
         end
         if (char_valid && (cyc >= free_at)) begin
            usr_at      = cyc + 1;
            usr_rs      = char_rs;
            usr_data    = char_data;
            free_at     = cyc + 2 + wlen(char_rs, char_data);
            acc_pending = 1'b1;
         end
      end
   endtask

   // Assert reset mid-cycle, check outputs drop at once, then release.
   task automatic pulse_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_start",     32'(start),      32'(1'b0));
      chk("rst_rs",        32'(rs),         32'(1'b0));
      chk("rst_datain",    32'(datain),     32'(8'h00));
      chk("rst_ready",     32'(char_ready), 32'(1'b0));
      chk("rst_init_done", 32'(init_done),  32'(1'b0));
      char_valid = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      rst = 1'b0;
   endtask

   initial begin
      rom = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h01, 8'h06};
      init_t[0] = P_PWR;
      for (int k = 1; k < 6; k++) init_t[k] = init_t[k-1] + 1 + wlen(1'b0, rom[k-1]);
      init_end = init_t[5] + 1 + wlen(1'b0, rom[5]);

      rst        = 1'b1;
      char_valid = 1'b0;
      char_rs    = 1'b0;
      char_data  = 8'h00;
      hold_mode  = 1'b0;
      cyc        = 0;
      repeat (3) @(negedge clk);
      chk("reset_start",     32'(start),      32'(1'b0));
      chk("reset_datain",    32'(datain),     32'(8'h00));
      chk("reset_ready",     32'(char_ready), 32'(1'b0));
      chk("reset_init_done", 32'(init_done),  32'(1'b0));
      model_reset();
      rst = 1'b0;

      // Init sequence with no user traffic.
      run_cycles(50);

      // Data byte, clear then data, ordinary command then data.
      tx_q.push_back({1'b1, 8'hA5});
      tx_q.push_back({1'b0, 8'h01});
      tx_q.push_back({1'b1, 8'h41});
      tx_q.push_back({1'b0, 8'h80});
      tx_q.push_back({1'b1, 8'h42});
      tx_q.push_back({1'b0, 8'h02});
      tx_q.push_back({1'b1, 8'h43});
      run_cycles(90);

      // Back-to-back bytes with valid held continuously.
      hold_mode = 1'b1;
      tx_q.push_back({1'b1, 8'h48});
      tx_q.push_back({1'b1, 8'h49});
      tx_q.push_back({1'b1, 8'h21});
      run_cycles(30);

      // Reset; a byte offered during power-up and init, reset again after 0x0C.
      pulse_reset();
      tx_q.push_back({1'b1, 8'h4B});
      run_cycles(init_t[3] + 2);
      pulse_reset();

      // Byte held from power-up, issued after init, reset during its wait.
      tx_q.delete();
      tx_q.push_back({1'b1, 8'h55});
      run_cycles(init_end + 3);
      pulse_reset();
      hold_mode = 1'b0;
      run_cycles(50);

      // Random traffic, biased towards clear/home and short commands.
      for (int j = 0; j < 25; j++) begin
         logic       r;
         logic [7:0] d;
         r = 1'($urandom_range(0, 1));
         d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom_range(0, 255));
         tx_q.push_back({r, d});
      end
      run_cycles(400);

      chk("start_count", 32'(obs_starts), 32'(exp_starts));
      chk("queue_drained", 32'(tx_q.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
